// File: rtl/slave_spi_trx_if.sv
// FIFO-side bundle of the SPI slave: TX show-ahead head/pop and RX push.
// The slave modport is the SPI block's view, master is the FIFO side.
interface slave_spi_trx_if;
    logic       empty_i;
    logic [7:0] tx_data_i;
    logic       fifo_rd_o;
    logic       tx_urun_o;
    logic       rx_full_i;
    logic [7:0] rx_data_o;
    logic       fifo_wr_o;
    logic       rx_ovr_o;

    modport slave (
        input  empty_i, tx_data_i, rx_full_i,
        output fifo_rd_o, tx_urun_o,
        output rx_data_o, fifo_wr_o, rx_ovr_o
    );

    modport master (
        output empty_i, tx_data_i, rx_full_i,
        input  fifo_rd_o, tx_urun_o,
        input  rx_data_o, fifo_wr_o, rx_ovr_o
    );
endinterface

// File: rtl/slave_spi_trx.sv
// Full-duplex SPI slave, all SPI pins oversampled in the sclk domain.
// Bytes received go to the RX FIFO, replies come from a show-ahead TX FIFO.
module slave_spi_trx (
    input  logic        sclk,
    input  logic        rstn,
    input  logic        ssck,
    input  logic        ssen,
    input  logic        ssci,
    output logic        ssco,
    input  logic [1:0]  mode_r,
    input  logic        sen_pol_r,
    slave_spi_trx_if.slave fifo
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] ck_s;
    logic [2:0] en_s;
    logic [1:0] di_s;
    logic [2:0] bcnt;
    logic [7:0] rxs;
    logic [7:0] txs;

    logic cpol;
    logic cpha;
    logic ck_rise;
    logic ck_fall;
    logic smp_edge;
    logic drv_edge;
    logic sel;
    logic sel_rise;
    logic load;
    logic shift;
    logic smp;
    logic clear;
    logic done;

    assign cpol     = mode_r[1];
    assign cpha     = mode_r[0];
    assign ck_rise  = ck_s[1] & ~ck_s[2];
    assign ck_fall  = ~ck_s[1] & ck_s[2];
    assign smp_edge = (cpol == cpha) ? ck_rise : ck_fall;
    assign drv_edge = (cpol == cpha) ? ck_fall : ck_rise;
    assign sel      = (en_s[1] == sen_pol_r);
    // Only a real select transition starts a frame, never the reset value.
    assign sel_rise = sel & (en_s[2] != sen_pol_r);
    assign ssco     = sel & (state_q == ACTIVE) & txs[7];

    // State register.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        smp     = 1'b0;
        clear   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_rise) begin
                    state_d = ACTIVE;
                    load    = ~cpha;
                end
            end
            ACTIVE: begin
                if (!sel) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                    done    = smp_edge && (bcnt == 3'd7);
                end else begin
                    if (smp_edge) begin
                        smp = 1'b1;
                        if (bcnt == 3'd7) begin
                            done = 1'b1;
                            load = ~cpha;
                        end
                    end
                    if (drv_edge) begin
                        if (cpha) begin
                            if (bcnt == 3'd0) load = 1'b1;
                            else              shift = 1'b1;
                        end else if (bcnt != 3'd0) begin
                            shift = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Synchronizers, shift registers, FIFO strobes and RX data.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            ck_s           <= 3'b000;
            en_s           <= 3'b000;
            di_s           <= 2'b00;
            bcnt           <= 3'd0;
            rxs            <= 8'h00;
            txs            <= 8'h00;
            fifo.fifo_rd_o <= 1'b0;
            fifo.tx_urun_o <= 1'b0;
            fifo.fifo_wr_o <= 1'b0;
            fifo.rx_ovr_o  <= 1'b0;
            fifo.rx_data_o <= 8'h00;
        end else begin
            ck_s           <= {ck_s[1:0], ssck};
            en_s           <= {en_s[1:0], ssen};
            di_s           <= {di_s[0], ssci};
            fifo.fifo_rd_o <= load & ~fifo.empty_i;
            fifo.tx_urun_o <= load & fifo.empty_i;
            fifo.fifo_wr_o <= done & ~fifo.rx_full_i;
            fifo.rx_ovr_o  <= done & fifo.rx_full_i;
            if (done && !fifo.rx_full_i) begin
                fifo.rx_data_o <= {rxs[6:0], di_s[1]};
            end
            if (clear) begin
                bcnt <= 3'd0;
                rxs  <= 8'h00;
                txs  <= 8'h00;
            end else begin
                if (smp) begin
                    bcnt <= bcnt + 3'd1;
                    rxs  <= {rxs[6:0], di_s[1]};
                end
                if (load) begin
                    txs <= fifo.empty_i ? 8'h00 : fifo.tx_data_i;
                end else if (shift) begin
                    txs <= {txs[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_slave_spi_trx.sv
// Bench for slave_spi_trx: a behavioural SPI master plus FIFO models.
// Expected bytes/counts come from FIFO order and load-per-byte rules.
module tb_slave_spi_trx;
    localparam int HP = 8;

    logic       sclk = 1'b0;
    logic       rstn;
    logic       ssck;
    logic       ssen;
    logic       ssci;
    logic       ssco;
    logic [1:0] mode;
    logic       pol;
    logic       full;

    logic [7:0] tx_mem [256];
    logic [7:0] rx_mem [256];
    int         tx_cnt = 0;
    int         rd_idx = 0;
    int         wr_idx = 0;
    int         urun_cnt = 0;
    int         ovr_cnt = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] last_rx;
    logic [7:0] mo [4];
    logic [7:0] mi [4];

    slave_spi_trx_if bus ();

    assign bus.empty_i   = (rd_idx == tx_cnt);
    assign bus.tx_data_i = tx_mem[rd_idx[7:0]];
    assign bus.rx_full_i = full;

    slave_spi_trx dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .ssck      (ssck),
        .ssen      (ssen),
        .ssci      (ssci),
        .ssco      (ssco),
        .mode_r    (mode),
        .sen_pol_r (pol),
        .fifo      (bus)
    );

    always #5 sclk = ~sclk;

    // FIFO side model: pop, push and error-pulse bookkeeping.
    always @(negedge sclk) begin
        if (bus.fifo_rd_o) rd_idx = rd_idx + 1;
        if (bus.tx_urun_o) urun_cnt = urun_cnt + 1;
        if (bus.rx_ovr_o)  ovr_cnt = ovr_cnt + 1;
        if (bus.fifo_wr_o) begin
            rx_mem[wr_idx[7:0]] = bus.rx_data_o;
            wr_idx = wr_idx + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_cnt[7:0]] = b;
        tx_cnt = tx_cnt + 1;
    endtask

    // Master shifts nb bits MSB-first using the current mode.
    task automatic spi_bits(input logic [7:0] b, input int nb,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!mode[0]) begin
                ssci = b[3'(i)];
                tick(HP);
                r[3'(i)] = ssco;
                ssck = ~ssck;
                tick(HP);
                ssck = ~ssck;
            end else begin
                ssck = ~ssck;
                ssci = b[3'(i)];
                tick(HP);
                r[3'(i)] = ssco;
                ssck = ~ssck;
                tick(HP);
            end
        end
    endtask

    // One select frame of nb bytes, then checks against the FIFO model.
    task automatic run(input logic [1:0] m, input logic p, input int nb);
        int s, w0, u0, o0, avail, loads, pops;
        logic [7:0] e;
        logic [7:0] r;
        mode = m;
        pol  = p;
        ssck = m[1];
        ssen = ~p;
        tick(8);
        s     = rd_idx;
        w0    = wr_idx;
        u0    = urun_cnt;
        o0    = ovr_cnt;
        avail = tx_cnt - rd_idx;
        chk("idle_ssco", int'(ssco), 0);
        ssen = p;
        tick(6);
        for (int n = 0; n < nb; n++) begin
            spi_bits(mo[n], 8, r);
            mi[n] = r;
        end
        tick(2);
        ssen = ~p;
        tick(8);
        loads = nb + (m[0] ? 0 : 1);
        pops  = (avail < loads) ? avail : loads;
        for (int n = 0; n < nb; n++) begin
            e = (n < avail) ? tx_mem[8'(s + n)] : 8'h00;
            chk("miso", int'(mi[n]), int'(e));
        end
        chk("pops", rd_idx - s, pops);
        chk("urun", urun_cnt - u0, loads - pops);
        if (!full) begin
            for (int n = 0; n < nb; n++) begin
                chk("rx_byte", int'(rx_mem[8'(w0 + n)]), int'(mo[n]));
            end
            chk("pushes", wr_idx - w0, nb);
            chk("ovr_none", ovr_cnt - o0, 0);
            chk("rx_data", int'(bus.rx_data_o), int'(mo[nb - 1]));
            last_rx = mo[nb - 1];
        end else begin
            chk("ovr_pushes", wr_idx - w0, 0);
            chk("ovr_pulses", ovr_cnt - o0, nb);
            chk("ovr_hold", int'(bus.rx_data_o), int'(last_rx));
        end
        chk("end_ssco", int'(ssco), 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_ssco", int'(ssco), 0);
        chk("rst_rd", int'(bus.fifo_rd_o), 0);
        chk("rst_urun", int'(bus.tx_urun_o), 0);
        chk("rst_wr", int'(bus.fifo_wr_o), 0);
        chk("rst_ovr", int'(bus.rx_ovr_o), 0);
        chk("rst_rxd", int'(bus.rx_data_o), 0);
    endtask

    initial begin
        int s, w0, u0;
        logic [7:0] r;
        logic [1:0] rm;
        logic       rp;
        int         rn;
        int         rf;
        rstn = 1'b0;
        ssck = 1'b0;
        ssen = 1'b1;
        ssci = 1'b0;
        mode = 2'd0;
        pol  = 1'b0;
        full = 1'b0;
        last_rx = 8'h00;
        tick(3);
        chk_reset_outs();
        rstn = 1'b1;
        tick(4);

        push_tx(8'h3C);
        mo[0] = 8'hA5;
        run(2'd0, 1'b0, 1);

        for (int m = 1; m < 4; m++) begin
            push_tx(8'h55);
            push_tx(8'hAA);
            mo[0] = 8'h81;
            mo[1] = 8'h7E;
            run(2'(m), 1'b0, 2);
        end

        mo[0] = 8'h5A;
        run(2'd1, 1'b0, 1);

        full  = 1'b1;
        mo[0] = 8'hF0;
        run(2'd0, 1'b0, 1);
        full  = 1'b0;

        push_tx(8'h11);
        mode = 2'd0;
        pol  = 1'b0;
        ssck = 1'b0;
        ssen = 1'b1;
        tick(8);
        w0   = wr_idx;
        ssen = 1'b0;
        tick(6);
        spi_bits(8'hB7, 5, r);
        tick(2);
        ssen = 1'b1;
        tick(8);
        chk("abort_push", wr_idx - w0, 0);
        chk("abort_ssco", int'(ssco), 0);
        push_tx(8'h22);
        mo[0] = 8'hC3;
        run(2'd0, 1'b1, 1);

        push_tx(8'h33);
        mode = 2'd0;
        pol  = 1'b0;
        ssck = 1'b0;
        ssen = 1'b1;
        tick(8);
        ssen = 1'b0;
        tick(6);
        spi_bits(8'h5E, 3, r);
        rstn = 1'b0;
        tick(2);
        chk_reset_outs();
        last_rx = 8'h00;
        rstn = 1'b1;
        tick(4);
        ssen = 1'b1;
        tick(8);
        push_tx(8'h44);
        mo[0] = 8'h96;
        run(2'd0, 1'b0, 1);

        push_tx(8'h66);
        mode = 2'd0;
        pol  = 1'b0;
        ssck = 1'b0;
        ssen = 1'b1;
        tick(8);
        s    = rd_idx;
        w0   = wr_idx;
        u0   = urun_cnt;
        ssen = 1'b0;
        tick(6);
        spi_bits(8'h4D, 7, r);
        ssci = 1'b1;
        tick(HP);
        ssck = 1'b1;
        ssen = 1'b1;
        tick(HP);
        ssck = 1'b0;
        tick(8);
        chk("coin_miso", int'(r & 8'hFE), int'(8'h66 & 8'hFE));
        chk("coin_push", wr_idx - w0, 1);
        chk("coin_byte", int'(rx_mem[8'(w0)]), int'(8'h4D));
        chk("coin_rxd", int'(bus.rx_data_o), int'(8'h4D));
        chk("coin_pops", rd_idx - s, 1);
        chk("coin_urun", urun_cnt - u0, 0);
        last_rx = 8'h4D;

        for (int it = 0; it < 6; it++) begin
            rm = 2'($urandom_range(0, 3));
            rp = 1'($urandom_range(0, 1));
            rn = $urandom_range(1, 3);
            rf = $urandom_range(0, 3);
            for (int k = 0; k < rf; k++) push_tx(8'($urandom_range(0, 255)));
            for (int k = 0; k < rn; k++) mo[k] = 8'($urandom_range(0, 255));
            run(rm, rp, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/slave_spi_trx.md
# slave_spi_trx

Full-duplex SPI slave: the far end of the `master_spi_tx` link. It receives `msck`/`msen`/`msco` from a master on the SPI pins and drives the master's MISO input. All SPI inputs are oversampled in the `sclk` domain, so the block needs no SPI-clock domain. Received bytes are pushed to an RX FIFO, and reply bytes are popped from a show-ahead TX FIFO.

## Interface
Parameters: none; the SPI mode and select polarity are set by the register ports below.

Ports:
- sclk  in  1  system clock; must be at least 8x the SPI bit rate
- rstn  in  1  asynchronous, active-low reset
- ssck  in  1  SPI clock from the master (asynchronous)
- ssen  in  1  SPI select from the master (asynchronous); active level set by sen_pol_r
- ssci  in  1  MOSI from the master (asynchronous)
- ssco  out 1  MISO to the master; 0 whenever not selected
- mode_r  in  2  bit1 = CPOL, bit0 = CPHA; static while selected
- sen_pol_r  in  1  1 = select active-high, 0 = select active-low
- empty_i  in  1  TX FIFO empty
- tx_data_i  in  8  TX FIFO head; valid while empty_i=0 (show-ahead)
- fifo_rd_o  out 1  TX pop, one-cycle pulse
- tx_urun_o  out 1  one-cycle pulse: a byte load found the TX FIFO empty, so 8'h00 is sent instead
- rx_full_i  in  1  RX FIFO full
- rx_data_o  out 8  last received byte, MSB-first assembly
- fifo_wr_o  out 1  RX push, one-cycle pulse, qualified by rx_data_o
- rx_ovr_o  out 1  one-cycle pulse: a byte completed while rx_full_i=1; the byte is dropped

## Operation
- **Synchronizers.** ssck, ssen and ssci each pass through 2 flops (s1, s2). A third flop s3 is added on ssck and ssen for edge detection.
  - Rise = s2 & ~s3; fall = ~s2 & s3.
  - sel = (ssen_s2 == sen_pol_r).
- **Edge roles.**
  - Sample edge = rising when CPOL == CPHA, otherwise falling.
  - Drive edge = the opposite edge.
  - Edges are ignored while sel = 0.
- **States.**
  - IDLE: sel=0. bcnt=0, ssco=0.
  - IDLE -> ACTIVE on sel assertion.
  - ACTIVE -> IDLE on sel deassertion, from any bcnt.
- **bcnt** is 3 bits and increments on every sample edge in ACTIVE. It wraps 7 -> 0, and that wrap is a byte boundary.
- **Receive.**
  - Each sample edge: rxs <= {rxs[6:0], ssci_s2}.
  - On the 8th sample edge (bcnt=7):
    - If rx_full_i=0: rx_data_o <= {rxs[6:0], ssci_s2} and fifo_wr_o=1.
    - If rx_full_i=1: rx_ovr_o=1 and rx_data_o holds its value.
- **Byte load** (a single shared operation):
  - If empty_i=0: txs <= tx_data_i and fifo_rd_o=1.
  - If empty_i=1: txs <= 8'h00 and tx_urun_o=1.
  - ssco = txs[7] while sel=1.
- **Transmit, CPHA=0.**
  - Byte load occurs on the sel assertion cycle and on the cycle of each 8th sample edge.
  - Drive edges shift txs left only when bcnt != 0, so the trailing edge after bit 7 does not disturb the newly loaded byte.
- **Transmit, CPHA=1.**
  - A drive edge with bcnt=0 performs the byte load.
  - A drive edge with bcnt != 0 shifts txs left.
- **Deselect mid-byte.** bcnt, rxs and txs are cleared. No fifo_wr_o is issued for the partial byte. A TX byte already popped is lost; no refetch.
- **Simultaneous events.** If the 8th sample edge and deselect are seen in the same cycle, the completed byte is still written (or flagged by rx_ovr_o), no reload occurs, and the state goes to IDLE.
- **At most one pop per byte.** fifo_rd_o and tx_urun_o are never both 1 in the same cycle.

## Timing
- **Reset values.** ssco=0, fifo_rd_o=0, tx_urun_o=0, rx_data_o=8'h00, fifo_wr_o=0, rx_ovr_o=0. State = IDLE; bcnt, rxs, txs and all synchronizer flops = 0.
- **Reset mid-transfer** returns the block to IDLE immediately. The first edge after reset release is evaluated against s3=0.
- **Pin to action.** A pin edge is captured in s1 at sclk edge k and reaches s2 at k+1. The registered action (shift, ssco change, fifo_wr_o, fifo_rd_o) is visible after edge k+2, i.e. 2-3 sclk of latency.
- **SPI half-period.** Each ssck half-period must be ≥ 4 sclk, so that ssco is settled before the master samples.
- **Select setup.** The select must lead the first ssck edge by ≥ 3 sclk.
- **Pulse width.** fifo_wr_o, fifo_rd_o, tx_urun_o and rx_ovr_o are exactly 1 sclk wide.
- **rx_data_o** changes only in the cycle fifo_wr_o=1.

## Test plan
- **Mode 0 single byte.** sen_pol_r=0; master sends 8'hA5 while the TX FIFO holds 8'h3C. Required: fifo_rd_o pulses once at select; master receives 8'h3C; rx_data_o=8'hA5 with one fifo_wr_o pulse.
- **Modes 1/2/3 back-to-back.** Two bytes per mode: 8'h81 then 8'h7E out; TX FIFO holds 8'h55, 8'hAA. Required: both directions correct in order; two pops; two pushes; no glitch on ssco at the byte boundary.
- **TX underrun.** empty_i=1 for the whole transfer. Required: master receives 8'h00; tx_urun_o pulses once per byte; fifo_rd_o stays 0.
- **RX overflow.** rx_full_i=1 at the 8th sample edge. Required: rx_ovr_o pulses; fifo_wr_o=0; rx_data_o keeps its previous value.
- **Abort and select polarity.** Deselect after 5 bits, then a full byte 8'hC3 is sent with sen_pol_r=1. Required: no push for the partial byte; the next byte is received as 8'hC3; ssco=0 while idle.
- **Reset and boundary.** rstn is pulsed mid-byte, then a transfer is repeated. Required: all outputs are at their reset values during reset, and the repeat transfer is correct. Separately, deselect coincident with the 8th sample edge: the byte is still pushed.
